// File: rtl/mips_mem_responder.sv
// Memory-side responder for the single-cycle Mips core.
// It provides instruction and data memory. It also holds an output-port
// register and a free-running cycle counter, both memory-mapped.
// A byte-serial loader fills instruction memory after reset. Until the
// program is loaded, cpu_hold keeps the core in reset.
//
// Loader handshake: a byte moves on a posedge where load_valid & load_ready.
// load_valid and load_byte/load_last are driven by the source and may change
// only after an accepting edge. load_ready depends only on FSM state and reset.
module mips_mem_responder #(
  parameter int          IMEM_WORDS = 64,
  parameter int          DMEM_WORDS = 64,
  parameter logic [31:0] IO_ADDR    = 32'hFFFF_FFF0,
  parameter logic [31:0] CNT_ADDR   = 32'hFFFF_FFF4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic [31:0] instr,
  input  logic        memwrite,
  input  logic [31:0] aluout,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        load_valid,
  input  logic [7:0]  load_byte,
  input  logic        load_last,
  output logic        load_ready,
  output logic        cpu_hold,
  output logic [31:0] io_out,
  output logic [31:0] cycles
);

  localparam int          IA         = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
  localparam int          DA         = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;
  localparam logic [31:0] IMEM_BYTES = 32'(4 * IMEM_WORDS);
  localparam logic [31:0] DMEM_BYTES = 32'(4 * DMEM_WORDS);
  localparam logic [IA-1:0] LAST_SLOT = IA'(IMEM_WORDS - 1);

  // LOAD: loader owns instruction memory and the core is held.
  // RUN: the core executes. Only reset leaves RUN.
  typedef enum logic {LOAD = 1'b0, RUN = 1'b1} state_t;

  state_t        state, state_nx;
  logic [IA-1:0] word_ptr, word_ptr_nx;
  logic [1:0]    byte_cnt, byte_cnt_nx;
  logic [31:0]   shift, shift_nx;
  logic [31:0]   assembled;
  logic          byte_accept;
  logic          imem_we;

  logic [31:0] imem [IMEM_WORDS];
  logic [31:0] dmem [DMEM_WORDS];

  logic [31:0] aluout_w;
  logic        hit_io, hit_cnt, hit_dmem;
  logic        store_en;

  assign load_ready  = (state == LOAD) & ~reset;
  assign cpu_hold    = (state == LOAD);
  assign byte_accept = load_valid & load_ready;

  // Insert the incoming byte into the partial word, big-endian (first byte on top)
  always_comb begin
    assembled = shift;
    case (byte_cnt)
      2'd0:    assembled[31:24] = load_byte;
      2'd1:    assembled[23:16] = load_byte;
      2'd2:    assembled[15:8]  = load_byte;
      default: assembled[7:0]   = load_byte;
    endcase
  end

  // Loader next-state: pack bytes, write completed/final words, move to RUN
  always_comb begin
    state_nx    = state;
    word_ptr_nx = word_ptr;
    byte_cnt_nx = byte_cnt;
    shift_nx    = shift;
    imem_we     = 1'b0;
    if (state == LOAD && byte_accept) begin
      byte_cnt_nx = byte_cnt + 2'd1;
      shift_nx    = assembled;
      if (byte_cnt == 2'd3 || load_last) begin
        // A final partial word is written with its unfilled low bytes still zero
        imem_we  = 1'b1;
        shift_nx = 32'h0;
      end
      if (byte_cnt == 2'd3) begin
        word_ptr_nx = word_ptr + IA'(1);
      end
      // Filling the last slot ends the load even without load_last
      if (load_last || (byte_cnt == 2'd3 && word_ptr == LAST_SLOT)) begin
        state_nx = RUN;
      end
    end
  end

  // Loader state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= LOAD;
      word_ptr <= '0;
      byte_cnt <= 2'd0;
      shift    <= 32'h0;
    end else begin
      state    <= state_nx;
      word_ptr <= word_ptr_nx;
      byte_cnt <= byte_cnt_nx;
      shift    <= shift_nx;
    end
  end

  // Instruction memory write port (loader only, not reset)
  always_ff @(posedge clk) begin
    if (imem_we) imem[word_ptr] <= assembled;
  end

  // Instruction fetch. Out-of-range pc returns zero and pc[1:0] is ignored.
  always_comb begin
    instr = 32'h0;
    if (pc < IMEM_BYTES) instr = imem[pc[IA+1:2]];
  end

  // Data-side address decode on the word-aligned address
  assign aluout_w = {aluout[31:2], 2'b00};
  assign hit_io   = (aluout_w == {IO_ADDR[31:2], 2'b00});
  assign hit_cnt  = (aluout_w == {CNT_ADDR[31:2], 2'b00});
  assign hit_dmem = (aluout < DMEM_BYTES);
  assign store_en = memwrite & ~cpu_hold;

  // Load data mux. The mapped registers take priority over dmem.
  always_comb begin
    readdata = 32'h0;
    if (hit_io)        readdata = io_out;
    else if (hit_cnt)  readdata = cycles;
    else if (hit_dmem) readdata = dmem[aluout[DA+1:2]];
  end

  // Data memory store port (not reset, so unwritten words read X)
  always_ff @(posedge clk) begin
    if (store_en && hit_dmem && !hit_io && !hit_cnt) dmem[aluout[DA+1:2]] <= writedata;
  end

  // Memory-mapped registers. A counter store overrides the RUN increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      io_out <= 32'h0;
      cycles <= 32'h0;
    end else begin
      if (store_en && hit_io) io_out <= writedata;
      if (store_en && hit_cnt)  cycles <= writedata;
      else if (state == RUN)    cycles <= cycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_mips_mem_responder.sv
// Directed bench for mips_mem_responder.
// dut_a uses the default sizes. dut_b uses a two-word instruction memory so
// that out-of-range fetches and the last-slot load end can be exercised.
module tb_mips_mem_responder;

  localparam logic [31:0] IO_ADDR  = 32'hFFFF_FFF0;
  localparam logic [31:0] CNT_ADDR = 32'hFFFF_FFF4;

  logic clk;

  logic        a_reset, a_memwrite, a_load_valid, a_load_last, a_load_ready, a_cpu_hold;
  logic [31:0] a_pc, a_instr, a_aluout, a_writedata, a_readdata, a_io_out, a_cycles;
  logic [7:0]  a_load_byte;

  logic        b_reset, b_memwrite, b_load_valid, b_load_last, b_load_ready, b_cpu_hold;
  logic [31:0] b_pc, b_instr, b_aluout, b_writedata, b_readdata, b_io_out, b_cycles;
  logic [7:0]  b_load_byte;

  int n_checks = 0;
  int n_err    = 0;

  mips_mem_responder dut_a (
    .clk(clk), .reset(a_reset), .pc(a_pc), .instr(a_instr),
    .memwrite(a_memwrite), .aluout(a_aluout), .writedata(a_writedata), .readdata(a_readdata),
    .load_valid(a_load_valid), .load_byte(a_load_byte), .load_last(a_load_last),
    .load_ready(a_load_ready), .cpu_hold(a_cpu_hold), .io_out(a_io_out), .cycles(a_cycles)
  );

  mips_mem_responder #(.IMEM_WORDS(2)) dut_b (
    .clk(clk), .reset(b_reset), .pc(b_pc), .instr(b_instr),
    .memwrite(b_memwrite), .aluout(b_aluout), .writedata(b_writedata), .readdata(b_readdata),
    .load_valid(b_load_valid), .load_byte(b_load_byte), .load_last(b_load_last),
    .load_ready(b_load_ready), .cpu_hold(b_cpu_hold), .io_out(b_io_out), .cycles(b_cycles)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock. Inputs change and outputs are sampled 1ns after posedge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [7:0] b, input logic last);
    a_load_valid = 1'b1;
    a_load_byte  = b;
    a_load_last  = last;
    step();
    a_load_valid = 1'b0;
    a_load_last  = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] b, input logic last);
    b_load_valid = 1'b1;
    b_load_byte  = b;
    b_load_last  = last;
    step();
    b_load_valid = 1'b0;
    b_load_last  = 1'b0;
  endtask

  initial begin
    a_reset = 1'b1; a_memwrite = 1'b0; a_load_valid = 1'b0; a_load_last = 1'b0;
    a_load_byte = 8'h0; a_pc = 32'h0; a_aluout = 32'h0; a_writedata = 32'h0;
    b_reset = 1'b1; b_memwrite = 1'b0; b_load_valid = 1'b0; b_load_last = 1'b0;
    b_load_byte = 8'h0; b_pc = 32'h0; b_aluout = 32'h0; b_writedata = 32'h0;

    // Reset state
    step(); step();
    chk("rst_hold",   {31'b0, a_cpu_hold},   32'h1);
    chk("rst_ready",  {31'b0, a_load_ready}, 32'h0);
    chk("rst_io",     a_io_out,              32'h0);
    chk("rst_cycles", a_cycles,              32'h0);
    a_reset = 1'b0;
    #1;
    chk("load_ready_after_rst", {31'b0, a_load_ready}, 32'h1);

    // Two-word program, with an idle cycle between the words
    send_a(8'h20, 0); send_a(8'h08, 0); send_a(8'h00, 0); send_a(8'h05, 0);
    step();
    chk("still_loading", {31'b0, a_cpu_hold}, 32'h1);
    send_a(8'hAC, 0); send_a(8'h08, 0); send_a(8'h00, 0); send_a(8'h10, 1);
    chk("run_hold",     {31'b0, a_cpu_hold},   32'h0);
    chk("run_ready",    {31'b0, a_load_ready}, 32'h0);
    chk("cycles_entry", a_cycles,              32'h0);
    a_pc = 32'h0; #1;
    chk("instr_pc0", a_instr, 32'h2008_0005);
    a_pc = 32'h4; #1;
    chk("instr_pc4", a_instr, 32'hAC08_0010);
    step();
    chk("cycles_first_inc", a_cycles, 32'h1);
    a_pc = 32'h6; #1;
    chk("instr_pc6_lowbits", a_instr, 32'hAC08_0010);
    a_pc = 32'h100; #1;
    chk("instr_out_of_range", a_instr, 32'h0);

    // Loader is ignored in RUN
    a_load_valid = 1'b1; a_load_byte = 8'hFF; a_load_last = 1'b1; #1;
    chk("run_ready_valid", {31'b0, a_load_ready}, 32'h0);
    step();
    a_load_valid = 1'b0; a_load_last = 1'b0;
    a_pc = 32'h0; #1;
    chk("run_loader_ignored", a_instr, 32'h2008_0005);

    // Data memory store and reads
    a_memwrite = 1'b1; a_aluout = 32'h10; a_writedata = 32'hDEAD_BEEF;
    step();
    a_memwrite = 1'b0; #1;
    chk("dmem_rd_10", a_readdata, 32'hDEAD_BEEF);
    a_aluout = 32'h12; #1;
    chk("dmem_rd_12", a_readdata, 32'hDEAD_BEEF);
    a_memwrite = 1'b1; a_aluout = 32'h10; a_writedata = 32'h1234_5678; #1;
    chk("dmem_rd_old", a_readdata, 32'hDEAD_BEEF);
    step();
    a_memwrite = 1'b0; #1;
    chk("dmem_rd_new", a_readdata, 32'h1234_5678);
    a_memwrite = 1'b1; a_aluout = 32'h100; a_writedata = 32'h5555_5555;
    step();
    a_memwrite = 1'b0; #1;
    chk("dmem_out_of_range", a_readdata, 32'h0);
    a_aluout = 32'h10; #1;
    chk("dmem_untouched", a_readdata, 32'h1234_5678);

    // Output port
    a_memwrite = 1'b1; a_aluout = IO_ADDR; a_writedata = 32'h0000_00A5;
    step();
    a_memwrite = 1'b0; #1;
    chk("io_out",     a_io_out,   32'h0000_00A5);
    chk("io_readback", a_readdata, 32'h0000_00A5);

    // Cycle counter store and wrap
    a_memwrite = 1'b1; a_aluout = CNT_ADDR; a_writedata = 32'hFFFF_FFFE;
    step();
    a_memwrite = 1'b0; #1;
    chk("cnt_store",    a_cycles,   32'hFFFF_FFFE);
    chk("cnt_readback", a_readdata, 32'hFFFF_FFFE);
    step();
    chk("cnt_max", a_cycles, 32'hFFFF_FFFF);
    step();
    chk("cnt_wrap", a_cycles, 32'h0);

    // Reset in the middle of the second word
    a_reset = 1'b1; step(); a_reset = 1'b0; #1;
    chk("rst2_io",     a_io_out, 32'h0);
    chk("rst2_cycles", a_cycles, 32'h0);
    send_a(8'h11, 0); send_a(8'h22, 0); send_a(8'h33, 0); send_a(8'h44, 0);
    send_a(8'hAA, 0); send_a(8'hBB, 0); send_a(8'hCC, 0);
    a_reset = 1'b1; #1;
    chk("midrst_hold",  {31'b0, a_cpu_hold},   32'h1);
    chk("midrst_ready", {31'b0, a_load_ready}, 32'h0);
    step();
    chk("midrst_ready_held", {31'b0, a_load_ready}, 32'h0);
    a_reset = 1'b0; #1;
    chk("midrst_release_ready", {31'b0, a_load_ready}, 32'h1);

    // Stores during LOAD are dropped
    a_memwrite = 1'b1; a_aluout = IO_ADDR; a_writedata = 32'h0000_00A5;
    step();
    a_memwrite = 1'b0; #1;
    chk("load_store_ignored", a_io_out, 32'h0);

    send_a(8'h01, 0); send_a(8'h02, 0); send_a(8'h03, 0); send_a(8'h04, 1);
    chk("reload_run", {31'b0, a_cpu_hold}, 32'h0);
    a_pc = 32'h0; #1;
    chk("reload_w0", a_instr, 32'h0102_0304);
    a_pc = 32'h4; #1;
    chk("reload_w1_kept", a_instr, 32'hAC08_0010);

    // Two-word instruction memory: padded last word and out-of-range fetch
    b_reset = 1'b0; #1;
    send_b(8'h11, 0); send_b(8'h22, 0); send_b(8'h33, 0); send_b(8'h44, 0);
    send_b(8'h55, 0); send_b(8'h66, 1);
    chk("b_run", {31'b0, b_cpu_hold}, 32'h0);
    b_pc = 32'h0; #1;
    chk("b_w0", b_instr, 32'h1122_3344);
    b_pc = 32'h4; #1;
    chk("b_w1_padded", b_instr, 32'h5566_0000);
    b_pc = 32'h8; #1;
    chk("b_pc8_zero", b_instr, 32'h0);

    // Filling the last slot ends the load without load_last
    b_reset = 1'b1; step(); b_reset = 1'b0; #1;
    send_b(8'h01, 0); send_b(8'h02, 0); send_b(8'h03, 0); send_b(8'h04, 0);
    chk("b_after_w0_hold", {31'b0, b_cpu_hold}, 32'h1);
    send_b(8'h05, 0); send_b(8'h06, 0); send_b(8'h07, 0); send_b(8'h08, 0);
    chk("b_lastslot_run", {31'b0, b_cpu_hold}, 32'h0);
    b_pc = 32'h4; #1;
    chk("b_lastslot_w1", b_instr, 32'h0506_0708);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mips_mem_responder.md
Name: mips_mem_responder

Overview:
Memory-side responder for the single-cycle Mips core. It provides the instruction word for the core's pc and the data word for its aluout address. It commits the core's stores and exposes two memory-mapped registers: an output port and a free-running cycle counter. A byte-serial loader fills instruction memory after reset and holds the core in reset until the program is loaded.

Parameters:
IMEM_WORDS, 64, instruction memory depth in 32-bit words (power of 2)
DMEM_WORDS, 64, data memory depth in 32-bit words (power of 2)
IO_ADDR, 32'hFFFF_FFF0, word address of output-port register
CNT_ADDR, 32'hFFFF_FFF4, word address of cycle-counter register

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
pc  in  32  core fetch address
instr  out  32  instruction word for pc
memwrite  in  1  core store strobe
aluout  in  32  core data address
writedata  in  32  core store data
readdata  out  32  load data for aluout
load_valid  in  1  loader byte valid
load_byte  in  8  loader byte
load_last  in  1  qualifies final byte of program
load_ready  out  1  loader accepts byte this cycle
cpu_hold  out  1  drive to core reset; high while loading
io_out  out  32  output-port register
cycles  out  32  cycle-counter value

Behaviour:
- Reset is "reset, asynchronous, active-high; clock clk". While reset is high or on its release: state=LOAD, word_ptr=0, byte_cnt=0, shift=0, io_out=0, cycles=0, cpu_hold=1. Memory arrays are not reset.
- load_ready = (state==LOAD) & ~reset. A byte is accepted on a posedge where load_valid & load_ready.
- FSM states: LOAD and RUN. RUN is left only by reset.
- LOAD, byte accept: bytes are packed big-endian (1st byte lands in [31:24], 4th in [7:0]) and byte_cnt increments mod 4.
  - On the 4th byte, the assembled word is written to imem[word_ptr] on the same edge, word_ptr increments, and shift clears.
- LOAD, load_last with an accepted byte: the partial word is zero-padded in its low bytes, written to imem[word_ptr] on that edge, and state goes to RUN.
- LOAD, last slot: if the 4th-byte write targets word_ptr==IMEM_WORDS-1, state goes to RUN on that edge regardless of load_last.
- RUN: cpu_hold=0, load_ready=0, loader inputs are ignored.
- instr (combinational) = imem[pc[log2(IMEM_WORDS)+1:2]] if pc < 4*IMEM_WORDS, else 32'h0. pc[1:0] is ignored.
- readdata (combinational), address word-aligned, aluout[1:0] ignored:
  - aluout==IO_ADDR: io_out.
  - aluout==CNT_ADDR: cycles.
  - aluout < 4*DMEM_WORDS: dmem word.
  - otherwise: 0.
  - Unwritten dmem words read X.
- Stores commit on posedge clk when memwrite & ~cpu_hold:
  - IO_ADDR: io_out <= writedata.
  - CNT_ADDR: cycles <= writedata.
  - In-range dmem: word written.
  - Otherwise: dropped.
- Stores are ignored in LOAD.
- A store is visible on readdata in the cycle after the edge. Read and write of the same address in one cycle returns old data.
- cycles increments by 1 each posedge in RUN and wraps 32'hFFFF_FFFF to 0. A CNT_ADDR store in the same cycle wins over the increment.
- The transition edge LOAD->RUN does not increment cycles; the first increment is on the following edge.
- Reset mid-load: the loader restarts at word 0. Previously written imem words remain but are overwritten by the new load.

Test Plan:
- Reset, then 8 bytes 20 08 00 05 AC 08 00 10 with load_last on the 8th -> imem[0]=32'h20080005, imem[1]=32'hAC080010. Next cycle: cpu_hold=0, load_ready=0. pc=4 gives instr=32'hAC080010.
- 6 bytes 11 22 33 44 55 66 with load_last on the 6th -> imem[1]=32'h55660000, state RUN. pc=8 beyond IMEM_WORDS=2 (via parameter override) gives instr=0.
- RUN: memwrite with aluout=32'h10, writedata=32'hDEADBEEF -> next cycle aluout=32'h10 gives readdata=32'hDEADBEEF. aluout=32'h12 also reads it.
- RUN: store 32'h0000_00A5 to IO_ADDR -> io_out=32'hA5. Stores during LOAD leave io_out=0.
- RUN: store 32'hFFFF_FFFE to CNT_ADDR -> cycles reads FFFFFFFE, FFFFFFFF, then 0 on following edges.
- Assert reset after 3 bytes of the 2nd word -> cpu_hold=1 and load_ready=0 while reset is high. After release, a 4-byte load rewrites imem[0] and imem[1] is unchanged.
